// File: rtl/adsr_env_if.sv
// adsr_env_if: envelope control/level bundle; master drives gate and rates, slave (adsr_env) returns level and state
interface adsr_env_if #(parameter int WIDTH = 10);
  logic             gate;
  logic [WIDTH-1:0] attack_step;
  logic [WIDTH-1:0] decay_step;
  logic [WIDTH-1:0] sustain_level;
  logic [WIDTH-1:0] release_step;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic [2:0]       state_o;
  modport master (output gate, attack_step, decay_step, sustain_level, release_step,
                  input out, busy, state_o);
  modport slave  (input gate, attack_step, decay_step, sustain_level, release_step,
                  output out, busy, state_o);
endinterface

// File: rtl/adsr_env.sv
// adsr_env: gate-triggered ADSR envelope; ports clk, rst (sync, active-high), bus (adsr_env_if.slave: gate, steps, sustain_level in; out, busy, state_o out); `define ADSR_GATE_SYNC_EN adds a 2-flop gate synchronizer
module adsr_env #(
  parameter int WIDTH    = 10,
  parameter int CLKSPEED = 48_000_000,
  parameter int TICK_HZ  = 1024
) (
  input logic         clk,
  input logic         rst,
  adsr_env_if.slave   bus
);
  localparam int DIV = CLKSPEED / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [2:0] IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4;
  logic [CW-1:0]       cnt;
  logic                tick, gate_s, gate_d, rise, fall;
  logic [2:0]          st, st_n;
  logic [WIDTH-1:0]    lvl, lvl_n;
  logic [WIDTH:0]      sum;
  logic signed [WIDTH:0] diff;
`ifdef ADSR_GATE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) sync <= rst ? 2'b00 : {sync[0], bus.gate};
  assign gate_s = sync[1];
`else
  assign gate_s = bus.gate;
`endif
  assign tick = cnt == CW'(DIV - 1);
  assign rise = gate_s & ~gate_d;
  assign fall = ~gate_s & gate_d;
  // one extra bit so overflow past MAX and underflow below 0 are visible
  assign sum  = {1'b0, lvl} + {1'b0, bus.attack_step};
  assign diff = $signed({1'b0, lvl}) - $signed({1'b0, bus.decay_step});
  // edges take precedence over ticks; a coinciding tick is dropped
  always_comb begin
    st_n  = st;
    lvl_n = lvl;
    if (rise) st_n = ATTACK;
    else if (fall && (st == ATTACK || st == DECAY || st == SUSTAIN)) st_n = RELEASE;
    else if (st == IDLE) lvl_n = '0;
    else if (tick) begin
      case (st)
        ATTACK: begin
          st_n  = sum >= {1'b0, MAX} ? DECAY : ATTACK;
          lvl_n = sum >= {1'b0, MAX} ? MAX : sum[WIDTH-1:0];
        end
        DECAY: begin
          st_n  = diff <= $signed({1'b0, bus.sustain_level}) ? SUSTAIN : DECAY;
          lvl_n = diff <= $signed({1'b0, bus.sustain_level}) ? bus.sustain_level : diff[WIDTH-1:0];
        end
        SUSTAIN: lvl_n = bus.sustain_level;
        RELEASE: begin
          st_n  = lvl <= bus.release_step ? IDLE : RELEASE;
          lvl_n = lvl <= bus.release_step ? '0 : lvl - bus.release_step;
        end
        default: begin
          st_n  = IDLE;
          lvl_n = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      gate_d <= 1'b0;
      st     <= IDLE;
      lvl    <= '0;
    end else begin
      cnt    <= tick ? '0 : cnt + CW'(1);
      gate_d <= gate_s;
      st     <= st_n;
      lvl    <= lvl_n;
    end
  end
  assign bus.out     = lvl;
  assign bus.busy    = st != IDLE;
  assign bus.state_o = st;
endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: table-driven check of adsr_env with DIV=16 plus collision and mid-envelope reset sequences
module tb_adsr_env;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  adsr_env_if #(.WIDTH(10)) bus();
  adsr_env #(.WIDTH(10), .CLKSPEED(16), .TICK_HZ(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // cycles since reset release; cyc%16==15 marks a tick cycle
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  typedef struct {
    int g; int a; int d; int s; int r; int tk; int o; int st;
  } vec_t;
  vec_t v[39];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_tick();
    int n;
    n = 0;
    step();
    while (cyc % 16 != 0 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("tick_timeout", 1, 0);
  endtask
  task automatic chk_all(input string name, input int o, input int st);
    chk({name, "_out"}, int'(bus.out), o);
    chk({name, "_state"}, int'(bus.state_o), st);
    chk({name, "_busy"}, int'(bus.busy), int'(st != 0));
  endtask
  initial begin
    int n;
    v[0]  = '{0, 256, 100, 600, 200, 1, 0, 0};
    v[1]  = '{1, 256, 100, 600, 200, 0, 0, 1};
    v[2]  = '{1, 256, 100, 600, 200, 1, 256, 1};
    v[3]  = '{1, 256, 100, 600, 200, 1, 512, 1};
    v[4]  = '{1, 256, 100, 600, 200, 1, 768, 1};
    v[5]  = '{1, 256, 100, 600, 200, 1, 1023, 2};
    v[6]  = '{1, 256, 100, 600, 200, 1, 923, 2};
    v[7]  = '{1, 256, 100, 600, 200, 1, 823, 2};
    v[8]  = '{1, 256, 100, 600, 200, 1, 723, 2};
    v[9]  = '{1, 256, 100, 600, 200, 1, 623, 2};
    v[10] = '{1, 256, 100, 600, 200, 1, 600, 3};
    v[11] = '{1, 256, 100, 600, 200, 1, 600, 3};
    v[12] = '{1, 256, 100, 300, 200, 0, 600, 3};
    v[13] = '{1, 256, 100, 300, 200, 0, 600, 3};
    v[14] = '{1, 256, 100, 300, 200, 1, 300, 3};
    v[15] = '{1, 256, 100, 600, 200, 1, 600, 3};
    v[16] = '{0, 256, 100, 600, 200, 0, 600, 4};
    v[17] = '{0, 256, 100, 600, 200, 1, 400, 4};
    v[18] = '{0, 256, 100, 600, 200, 1, 200, 4};
    v[19] = '{0, 256, 100, 600, 200, 1, 0, 0};
    v[20] = '{0, 256, 100, 600, 200, 1, 0, 0};
    v[21] = '{1, 256, 100, 600, 200, 0, 0, 1};
    v[22] = '{1, 256, 100, 600, 200, 1, 256, 1};
    v[23] = '{1, 256, 100, 600, 200, 1, 512, 1};
    v[24] = '{1, 256, 100, 600, 200, 1, 768, 1};
    v[25] = '{1, 256, 100, 600, 200, 1, 1023, 2};
    v[26] = '{1, 256, 100, 600, 200, 1, 923, 2};
    v[27] = '{1, 256, 100, 600, 200, 1, 823, 2};
    v[28] = '{1, 256, 100, 600, 200, 1, 723, 2};
    v[29] = '{1, 256, 100, 600, 200, 1, 623, 2};
    v[30] = '{1, 256, 100, 600, 200, 1, 600, 3};
    v[31] = '{0, 256, 100, 600, 200, 0, 600, 4};
    v[32] = '{0, 256, 100, 600, 200, 1, 400, 4};
    v[33] = '{1, 256, 100, 600, 200, 0, 400, 1};
    v[34] = '{1, 256, 100, 600, 200, 1, 656, 1};
    v[35] = '{1, 256, 100, 600, 200, 1, 912, 1};
    v[36] = '{1, 256, 100, 600, 200, 1, 1023, 2};
    v[37] = '{0, 256, 100, 600, 1023, 0, 1023, 4};
    v[38] = '{0, 256, 100, 600, 1023, 1, 0, 0};
    bus.gate = 1'b0;
    bus.attack_step = '0;
    bus.decay_step = '0;
    bus.sustain_level = '0;
    bus.release_step = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 10 == 0) chk_all("idle_hold", 0, 0);
    end
    for (int i = 0; i < 39; i++) begin
      bus.gate = v[i].g[0];
      bus.attack_step = 10'(v[i].a);
      bus.decay_step = 10'(v[i].d);
      bus.sustain_level = 10'(v[i].s);
      bus.release_step = 10'(v[i].r);
      if (v[i].tk != 0) wait_tick();
      else step();
      chk_all($sformatf("vec%0d", i), v[i].o, v[i].st);
    end
    n = 0;
    while (cyc % 16 != 15 && n < 40) begin
      step();
      n++;
    end
    bus.gate = 1'b1;
    bus.attack_step = 10'd256;
    step();
    chk_all("collide_edge", 0, 1);
    step();
    chk_all("collide_hold", 0, 1);
    wait_tick();
    chk_all("collide_first_inc", 256, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("midreset", 0, 0);
    step();
    chk_all("midreset_retrig", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
